// File: rtl/sdram_sched_pkg.sv
// Shared types and default sizes for the SDRAM read/write command scheduler.
package sdram_sched_pkg;

  localparam int unsigned ADDR_W_DEF    = 26;
  localparam int unsigned BURST_LEN_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARB,
    BURST,
    GAP
  } state_t;

  typedef enum logic {
    DIR_WRITE = 1'b0,
    DIR_READ  = 1'b1
  } dir_t;

endpackage

// File: rtl/sdram_rw_scheduler_if.sv
// Request/command bundle between the requesters, the SDRAM command port and the scheduler.
interface sdram_rw_scheduler_if import sdram_sched_pkg::*; #(
  parameter int unsigned ADDR_W = ADDR_W_DEF
);
  logic              start;
  logic [ADDR_W-1:0] start_address;
  logic [ADDR_W-1:0] finish_address;
  logic              rd_req;
  logic              wr_req;
  logic              sdram_cmd_ready;
  logic              rd_grant;
  logic              wr_grant;
  logic              sdram_cmd_valid;
  logic              sdram_cmd_we;
  logic              calc_load;
  logic              calc_mode;
  logic              calc_enable;
  logic              burst_done;
  logic              busy;
  logic              region_done;

  modport master (
    output start, start_address, finish_address, rd_req, wr_req, sdram_cmd_ready,
    input  rd_grant, wr_grant, sdram_cmd_valid, sdram_cmd_we, calc_load, calc_mode,
           calc_enable, burst_done, busy, region_done
  );

  modport slave (
    input  start, start_address, finish_address, rd_req, wr_req, sdram_cmd_ready,
    output rd_grant, wr_grant, sdram_cmd_valid, sdram_cmd_we, calc_load, calc_mode,
           calc_enable, burst_done, busy, region_done
  );
endinterface

// File: rtl/sdram_rr_arb2.sv
// Two-way round-robin picker: when both directions are eligible, the one not served last wins.
module sdram_rr_arb2 import sdram_sched_pkg::*; (
  input  logic eligible_rd,
  input  logic eligible_wr,
  input  dir_t last,
  output logic grant_vld_c,
  output dir_t grant_dir_c
);

  always_comb begin
    grant_vld_c = eligible_rd | eligible_wr;
    grant_dir_c = DIR_WRITE;
    if (eligible_rd && eligible_wr) begin
      grant_dir_c = (last == DIR_READ) ? DIR_WRITE : DIR_READ;
    end else if (eligible_rd) begin
      grant_dir_c = DIR_READ;
    end
  end

endmodule

// File: rtl/sdram_rw_scheduler.sv
// Shares the SDRAM command port between one reader and one writer in round-robin bursts
// and steers sdram_address_calc so its address follows every accepted beat.
module sdram_rw_scheduler import sdram_sched_pkg::*; #(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  sdram_rw_scheduler_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   rd_left_q, rd_left_d;
  logic [ADDR_W-1:0]   wr_left_q, wr_left_d;
  logic [CNT_W-1:0]    beats_q, beats_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  dir_t                last_q, last_d;
  dir_t                mode_q, mode_d;
  logic                rd_grant_q, rd_grant_d;
  logic                wr_grant_q, wr_grant_d;
  logic                valid_q, valid_d;
  logic                we_q, we_d;
  logic                load_q, load_d;
  logic                burst_done_q, burst_done_d;
  logic                busy_q, busy_d;
  logic                region_done_q, region_done_d;

  logic                elig_rd_c, elig_wr_c, grant_vld_c, accept_c;
  dir_t                grant_dir_c;
  logic [ADDR_W-1:0]   len_c, dir_left_c;

  assign elig_rd_c  = bus.rd_req && (rd_left_q != '0);
  assign elig_wr_c  = bus.wr_req && (wr_left_q != '0);
  assign accept_c   = valid_q && bus.sdram_cmd_ready;
  assign len_c      = (bus.finish_address > bus.start_address) ?
                      (bus.finish_address - bus.start_address) : '0;
  assign dir_left_c = (grant_dir_c == DIR_READ) ? rd_left_q : wr_left_q;

  sdram_rr_arb2 u_arb (
    .eligible_rd (elig_rd_c),
    .eligible_wr (elig_wr_c),
    .last        (last_q),
    .grant_vld_c (grant_vld_c),
    .grant_dir_c (grant_dir_c)
  );

  // Next state and counters; registered outputs are derived from the next state below.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    rd_left_d     = rd_left_q;
    wr_left_d     = wr_left_q;
    beats_d       = beats_q;
    beat_cnt_d    = beat_cnt_q;
    last_d        = last_q;
    mode_d        = mode_q;
    busy_d        = busy_q;
    region_done_d = region_done_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d   = len_c;
          state_d = LOAD;
        end
      end
      LOAD: begin
        rd_left_d = len_q;
        wr_left_d = len_q;
        if (len_q == '0) begin
          region_done_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end else begin
          region_done_d = 1'b0;
          busy_d        = 1'b1;
          state_d       = ARB;
        end
      end
      ARB: begin
        if (bus.start) begin
          len_d   = len_c;
          state_d = LOAD;
        end else if (grant_vld_c) begin
          mode_d     = grant_dir_c;
          beats_d    = (dir_left_c >= ADDR_W'(BURST_LEN)) ? CNT_W'(BURST_LEN)
                                                          : CNT_W'(dir_left_c);
          beat_cnt_d = '0;
          state_d    = BURST;
        end
      end
      BURST: begin
        if (accept_c) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (mode_q == DIR_READ) rd_left_d = rd_left_q - ADDR_W'(1);
          else                    wr_left_d = wr_left_q - ADDR_W'(1);
          if ((beat_cnt_q + CNT_W'(1)) == beats_q) state_d = GAP;
        end
      end
      GAP: begin
        last_d = mode_q;
        if ((rd_left_q == '0) && (wr_left_q == '0)) begin
          region_done_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end else begin
          state_d = ARB;
        end
      end
      default: state_d = IDLE;
    endcase

    load_d       = (state_d == LOAD);
    valid_d      = (state_d == BURST);
    rd_grant_d   = valid_d && (mode_d == DIR_READ);
    wr_grant_d   = valid_d && (mode_d == DIR_WRITE);
    we_d         = valid_d && (mode_d == DIR_WRITE);
    burst_done_d = (state_d == GAP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      len_q         <= '0;
      rd_left_q     <= '0;
      wr_left_q     <= '0;
      beats_q       <= '0;
      beat_cnt_q    <= '0;
      last_q        <= DIR_WRITE;
      mode_q        <= DIR_READ;
      rd_grant_q    <= 1'b0;
      wr_grant_q    <= 1'b0;
      valid_q       <= 1'b0;
      we_q          <= 1'b0;
      load_q        <= 1'b0;
      burst_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      region_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      rd_left_q     <= rd_left_d;
      wr_left_q     <= wr_left_d;
      beats_q       <= beats_d;
      beat_cnt_q    <= beat_cnt_d;
      last_q        <= last_d;
      mode_q        <= mode_d;
      rd_grant_q    <= rd_grant_d;
      wr_grant_q    <= wr_grant_d;
      valid_q       <= valid_d;
      we_q          <= we_d;
      load_q        <= load_d;
      burst_done_q  <= burst_done_d;
      busy_q        <= busy_d;
      region_done_q <= region_done_d;
    end
  end

  // calc_enable must hit the calc in the same cycle the beat is accepted.
  assign bus.calc_enable     = accept_c;
  assign bus.rd_grant        = rd_grant_q;
  assign bus.wr_grant        = wr_grant_q;
  assign bus.sdram_cmd_valid = valid_q;
  assign bus.sdram_cmd_we    = we_q;
  assign bus.calc_load       = load_q;
  assign bus.calc_mode       = (mode_q == DIR_READ);
  assign bus.burst_done      = burst_done_q;
  assign bus.busy            = busy_q;
  assign bus.region_done     = region_done_q;

endmodule

// File: tb/tb_sdram_rw_scheduler.sv
// Scoreboard bench: a burst-level model queues expected beats, a monitor pops them per accepted command.
module tb_sdram_rw_scheduler;
  import sdram_sched_pkg::*;

  localparam int unsigned AW = 26;
  localparam int unsigned BL = 8;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_rw_scheduler_if #(.ADDR_W(AW)) bif ();
  sdram_rw_scheduler #(.ADDR_W(AW), .BURST_LEN(BL)) dut (.clk(clk), .rst(rst), .bus(bif));

  int vectors = 0;
  int miscompares = 0;

  beat_t         exp_q[$];
  int            m_rd_left, m_wr_left, exp_bursts, exp_loads;
  bit            m_last_rd, exp_done;
  logic [AW-1:0] m_rd_addr, m_wr_addr;

  int            bd_seen, load_seen, valid_seen, beats_acc, idle_run;
  bit            gap_en, gap_armed;
  int            rdy_mode;
  logic [AW-1:0] rd_ptr, wr_ptr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stand-in for sdram_address_calc, driven only by the scheduler's calc_* outputs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (bif.calc_load) begin
      rd_ptr <= bif.start_address;
      wr_ptr <= bif.finish_address;
    end else if (bif.calc_enable) begin
      if (bif.calc_mode) rd_ptr <= rd_ptr + 1'b1;
      else               wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // Reference: with request levels held, serve bursts until no direction is eligible.
  task automatic model_run(input bit rq, input bit wq);
    bit er, ew, dr;
    int n;
    while (1) begin
      er = rq && (m_rd_left > 0);
      ew = wq && (m_wr_left > 0);
      if (!er && !ew) break;
      dr = (er && ew) ? !m_last_rd : er;
      n  = dr ? m_rd_left : m_wr_left;
      if (n > int'(BL)) n = int'(BL);
      for (int i = 0; i < n; i++) begin
        if (dr) begin
          exp_q.push_back('{we: 1'b0, addr: m_rd_addr});
          m_rd_addr = m_rd_addr + 1'b1;
        end else begin
          exp_q.push_back('{we: 1'b1, addr: m_wr_addr});
          m_wr_addr = m_wr_addr + 1'b1;
        end
      end
      if (dr) m_rd_left -= n;
      else    m_wr_left -= n;
      m_last_rd = dr;
      exp_bursts++;
    end
    exp_done = (m_rd_left == 0) && (m_wr_left == 0);
  endtask

  task automatic new_region(input logic [AW-1:0] s, input logic [AW-1:0] f, input bit rq, input bit wq);
    logic [AW-1:0] d;
    @(posedge clk); #1;
    bif.rd_req = rq; bif.wr_req = wq;
    bif.start = 1'b1; bif.start_address = s; bif.finish_address = f;
    d = f - s;
    m_rd_left = (f > s) ? int'(d) : 0;
    m_wr_left = m_rd_left;
    m_rd_addr = s;
    m_wr_addr = f;
    exp_loads++;
    model_run(rq, wq);
    @(posedge clk); #1;
    bif.start = 1'b0;
  endtask

  task automatic set_reqs(input bit rq, input bit wq);
    @(posedge clk); #1;
    bif.rd_req = rq; bif.wr_req = wq;
    model_run(rq, wq);
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (exp_q.size() > 0 && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: %0d beats outstanding, required 0", nm, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({nm, "_region_done"}, 64'(bif.region_done), 64'(exp_done));
    chk({nm, "_busy"},        64'(bif.busy),        64'(!exp_done));
    chk({nm, "_bursts"},      64'(bd_seen),         64'(exp_bursts));
    chk({nm, "_loads"},       64'(load_seen),       64'(exp_loads));
  endtask

  task automatic check_reset_outs(input string nm);
    chk({nm, "_rd_grant"},    64'(bif.rd_grant),        64'(0));
    chk({nm, "_wr_grant"},    64'(bif.wr_grant),        64'(0));
    chk({nm, "_valid"},       64'(bif.sdram_cmd_valid), 64'(0));
    chk({nm, "_we"},          64'(bif.sdram_cmd_we),    64'(0));
    chk({nm, "_calc_load"},   64'(bif.calc_load),       64'(0));
    chk({nm, "_calc_mode"},   64'(bif.calc_mode),       64'(1));
    chk({nm, "_calc_enable"}, 64'(bif.calc_enable),     64'(0));
    chk({nm, "_burst_done"},  64'(bif.burst_done),      64'(0));
    chk({nm, "_busy"},        64'(bif.busy),            64'(0));
    chk({nm, "_region_done"}, 64'(bif.region_done),     64'(0));
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = toggling.
  initial begin
    bif.sdram_cmd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       bif.sdram_cmd_ready = 1'($urandom_range(0, 1));
        2:       bif.sdram_cmd_ready = ~bif.sdram_cmd_ready;
        default: bif.sdram_cmd_ready = 1'b1;
      endcase
    end
  end

  // Monitor: compares every accepted beat against the scoreboard and checks handshake rules.
  initial begin
    bit   prev_v = 0, prev_r = 0, prev_we = 0, prev_mode = 0;
    beat_t b;
    logic [AW-1:0] act_addr;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 0;
        continue;
      end
      if (bif.calc_load)  load_seen++;
      if (bif.burst_done) bd_seen++;
      if (prev_v && !prev_r) begin
        chk("hold_valid", 64'(bif.sdram_cmd_valid), 64'(1));
        chk("hold_we",    64'(bif.sdram_cmd_we),    64'(prev_we));
        chk("hold_mode",  64'(bif.calc_mode),       64'(prev_mode));
      end
      if (bif.sdram_cmd_valid) begin
        valid_seen++;
        chk("mode_vs_we",  64'(bif.calc_mode),   64'(!bif.sdram_cmd_we));
        chk("calc_enable", 64'(bif.calc_enable), 64'(bif.sdram_cmd_ready));
        if (gap_en && gap_armed && idle_run > 0) chk("gap_cycles", 64'(idle_run), 64'(2));
        if (gap_en) gap_armed = 1;
        idle_run = 0;
        if (bif.sdram_cmd_ready) begin
          act_addr = bif.calc_mode ? rd_ptr : wr_ptr;
          if (exp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_beat: got we=%0b addr=%0d, required no beat", bif.sdram_cmd_we, act_addr);
          end else begin
            b = exp_q.pop_front();
            chk("beat_we",       64'(bif.sdram_cmd_we), 64'(b.we));
            chk("beat_addr",     64'(act_addr),         64'(b.addr));
            chk("beat_rd_grant", 64'(bif.rd_grant),     64'(!b.we));
            chk("beat_wr_grant", 64'(bif.wr_grant),     64'(b.we));
            beats_acc++;
          end
        end
      end else begin
        idle_run++;
        chk("grant_idle",  64'({bif.rd_grant, bif.wr_grant}), 64'(0));
        chk("enable_idle", 64'(bif.calc_enable),              64'(0));
      end
      prev_v = bif.sdram_cmd_valid; prev_r = bif.sdram_cmd_ready;
      prev_we = bif.sdram_cmd_we;   prev_mode = bif.calc_mode;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, v0;
    logic [AW-1:0] s, f;
    rst = 1'b1;
    rdy_mode = 0;
    bif.start = 1'b0; bif.rd_req = 1'b0; bif.wr_req = 1'b0;
    bif.start_address = '0; bif.finish_address = '0;
    m_last_rd = 0; m_rd_left = 0; m_wr_left = 0; exp_done = 0;
    exp_bursts = 0; exp_loads = 0; bd_seen = 0; load_seen = 0;
    valid_seen = 0; beats_acc = 0; idle_run = 0; gap_en = 0; gap_armed = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Reads only over a long region, then writes finish it.
    new_region(26'd300, 26'd3000, 1'b1, 1'b0);
    drain("t1_reads");
    set_reqs(1'b0, 1'b1);
    drain("t1_writes");

    // Both requesting: alternating bursts with a fixed two-cycle turnaround.
    gap_en = 1; gap_armed = 0;
    new_region(26'd2000, 26'd3000, 1'b1, 1'b1);
    drain("t2_alt");
    gap_en = 0;

    // Truncated final burst; region completes only after writes.
    new_region(26'd100, 26'd111, 1'b1, 1'b0);
    drain("t3_reads");
    set_reqs(1'b0, 1'b1);
    drain("t3_writes");

    // Ready toggling during bursts.
    rdy_mode = 2;
    new_region(26'd700, 26'd708, 1'b1, 1'b1);
    drain("t4_toggle");
    rdy_mode = 0;

    // Empty region.
    new_region(26'd500, 26'd500, 1'b1, 1'b1);
    drain("t5_empty");

    // Random regions, random ready, random request levels then both to completion.
    rdy_mode = 1;
    for (int r = 0; r < 12; r++) begin
      s = AW'($urandom_range(10, 1000));
      f = ($urandom_range(0, 4) == 0) ? s - AW'($urandom_range(0, 3)) : s + AW'($urandom_range(0, 40));
      new_region(s, f, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      drain("rnd_phase1");
      set_reqs(1'b1, 1'b1);
      drain("rnd_phase2");
    end
    rdy_mode = 0;

    // Reset in the middle of a read burst.
    v0 = beats_acc;
    new_region(26'd300, 26'd3000, 1'b1, 1'b0);
    t = 0;
    while (beats_acc < v0 + 4 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("t6_reached_beat4", 64'(beats_acc - v0), 64'(4));
    rst = 1'b1;
    #1;
    check_reset_outs("t6_midburst");
    exp_q.delete();
    m_last_rd = 0; m_rd_left = 0; m_wr_left = 0; exp_done = 0;
    exp_bursts = 0; exp_loads = 0; bd_seen = 0; load_seen = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    v0 = valid_seen;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("t6_no_grant_after_reset", 64'(valid_seen - v0), 64'(0));
    chk("t6_busy",                 64'(bif.busy),        64'(0));

    // After reset, arbitration history restarts with read first.
    new_region(26'd40, 26'd60, 1'b1, 1'b1);
    drain("t6_restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
